cfu_seq: RTL

//   Multi-cycle sequencer between the CPU execute stage and a multi-cycle CFU datapath.

---
 rtl/cfu_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/cfu_seq.sv
// cfu_seq: sequencer between the CPU execute stage and a multi-cycle CFU datapath.
// Captures a CFU instruction, pulses dp_start_o and stalls the CPU until the datapath
// reports done or the busy counter expires. Ops flagged in FAST_MASK pass straight through.
module cfu_seq #(
  parameter logic [7:0]  FAST_MASK   = 8'h00,
  parameter int unsigned TIMEOUT     = 256,
  parameter logic [31:0] TIMEOUT_VAL = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        stall_o,
  output logic [31:0] rslt_o,
  output logic        dp_start_o,
  output logic [2:0]  dp_funct3_o,
  output logic [6:0]  dp_funct7_o,
  output logic [31:0] dp_src1_o,
  output logic [31:0] dp_src2_o,
  input  logic        dp_done_i,
  input  logic [31:0] dp_rslt_i,
  output logic        err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic [6:0]      f7_q;
  logic [31:0]     s1_q, s2_q;
  logic [31:0]     rslt_q, rslt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            err_q, err_d;
  logic            issue;
  logic            fast;

  assign fast       = FAST_MASK[funct3_i];
  assign dp_start_o = start_q;
  assign err_o      = err_q;

  // State, counter, captured operands/result and sticky error register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      f3_q    <= '0;
      f7_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      rslt_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rslt_q  <= rslt_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      err_q   <= err_d;
      if (issue) begin
        f3_q <= funct3_i;
        f7_q <= funct7_i;
        s1_q <= src1_i;
        s2_q <= src2_i;
      end
    end
  end

  // Next-state logic and all outputs; every output is zero unless a state drives it.
  always_comb begin
    state_d     = state_q;
    rslt_d      = rslt_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    err_d       = err_q;
    issue       = 1'b0;
    stall_o     = 1'b0;
    rslt_o      = '0;
    dp_funct3_o = '0;
    dp_funct7_o = '0;
    dp_src1_o   = '0;
    dp_src2_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          if (fast) begin
            dp_funct3_o = funct3_i;
            dp_funct7_o = funct7_i;
            dp_src1_o   = src1_i;
            dp_src2_o   = src2_i;
            rslt_o      = dp_rslt_i;
          end else begin
            issue   = 1'b1;
            stall_o = 1'b1;
            cnt_d   = '0;
            start_d = 1'b1;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        stall_o     = 1'b1;
        dp_funct3_o = f3_q;
        dp_funct7_o = f7_q;
        dp_src1_o   = s1_q;
        dp_src2_o   = s2_q;
        cnt_d       = cnt_q + CntW'(1);
        // A done on the final counted cycle still wins over the timeout.
        if (dp_done_i) begin
          rslt_d  = dp_rslt_i;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          rslt_d  = TIMEOUT_VAL;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        dp_funct3_o = f3_q;
        dp_funct7_o = f7_q;
        dp_src1_o   = s1_q;
        dp_src2_o   = s2_q;
        if (en_i) rslt_o = rslt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
